// File: rtl/pulse_stretch_pkg.sv
// Shared types and defaults for the pulse stretcher bank and its lanes.
package pulse_stretch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STRETCH = 2'd1,
    HOLDOFF = 2'd2
  } lane_state_e;

  localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/pulse_stretcher_bank_if.sv
// Bundle of the per-lane trigger/control inputs and stretched outputs.
interface pulse_stretcher_bank_if
  import pulse_stretch_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = CNT_W_DEF
);
  logic [CHANNELS-1:0] trig;
  logic [CHANNELS-1:0] cancel;
  logic [CNT_W-1:0]    len;
  logic [CNT_W-1:0]    holdoff;
  logic                retrig;
  logic [CHANNELS-1:0] pulse;
  logic [CHANNELS-1:0] done;
  logic                any_busy;

  modport master (
    output trig, cancel, len, holdoff, retrig,
    input  pulse, done, any_busy
  );

  modport slave (
    input  trig, cancel, len, holdoff, retrig,
    output pulse, done, any_busy
  );
endinterface

// File: rtl/pulse_stretch_lane.sv
// One stretcher lane: IDLE -> STRETCH for len cycles -> optional HOLDOFF dead time.
module pulse_stretch_lane
  import pulse_stretch_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tev,
  input  logic             cancel,
  input  logic [CNT_W-1:0] len,
  input  logic [CNT_W-1:0] holdoff,
  input  logic             retrig,
  output logic             pulse,
  output logic             done,
  output logic             busy
);

  lane_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (cancel) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (tev && len != '0) begin
            state_d = STRETCH;
            cnt_d   = len;
          end
        end
        STRETCH: begin
          // a retrigger on the last cycle keeps the pulse alive and suppresses done
          if (retrig && tev && len != '0) begin
            cnt_d = len;
          end else if (cnt_q == CNT_W'(1)) begin
            done_d = 1'b1;
            if (holdoff != '0) begin
              state_d = HOLDOFF;
              cnt_d   = holdoff;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        HOLDOFF: begin
          if (cnt_q == CNT_W'(1)) state_d = IDLE;
          else                    cnt_d   = cnt_q - CNT_W'(1);
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    pulse_d = (state_d == STRETCH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
    end
  end

  assign pulse = pulse_q;
  assign done  = done_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: rtl/pulse_stretcher_bank.sv
// Multi-lane programmable pulse stretcher: trigger edge detection plus one lane per channel.
module pulse_stretcher_bank
  import pulse_stretch_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int EDGE_TRIG = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  pulse_stretcher_bank_if.slave bus
);

  logic [CHANNELS-1:0] trig_q, trig_d;
  logic [CHANNELS-1:0] tev;
  logic [CHANNELS-1:0] pulse_w, done_w, busy_w;

  always_comb trig_d = bus.trig;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) trig_q <= '0;
    else     trig_q <= trig_d;
  end

  generate
    if (EDGE_TRIG != 0) begin : g_edge
      assign tev = bus.trig & ~trig_q;
    end else begin : g_level
      assign tev = bus.trig;
    end
  endgenerate

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    pulse_stretch_lane #(.CNT_W(CNT_W)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .tev     (tev[i]),
      .cancel  (bus.cancel[i]),
      .len     (bus.len),
      .holdoff (bus.holdoff),
      .retrig  (bus.retrig),
      .pulse   (pulse_w[i]),
      .done    (done_w[i]),
      .busy    (busy_w[i])
    );
  end

  assign bus.pulse    = pulse_w;
  assign bus.done     = done_w;
  assign bus.any_busy = |busy_w;

endmodule

// File: tb/tb_pulse_stretcher_bank.sv
// Directed, table-driven bench for pulse_stretcher_bank (edge and level trigger builds).
module tb_pulse_stretcher_bank;

  localparam int CH = 4;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pulse_stretcher_bank_if #(.CHANNELS(CH), .CNT_W(CW)) bus_e ();
  pulse_stretcher_bank_if #(.CHANNELS(CH), .CNT_W(CW)) bus_l ();

  pulse_stretcher_bank #(.CHANNELS(CH), .CNT_W(CW), .EDGE_TRIG(1)) u_dut_edge (
    .clk (clk),
    .rst (rst),
    .bus (bus_e.slave)
  );

  pulse_stretcher_bank #(.CHANNELS(CH), .CNT_W(CW), .EDGE_TRIG(0)) u_dut_lvl (
    .clk (clk),
    .rst (rst),
    .bus (bus_l.slave)
  );

  typedef struct {
    logic [CH-1:0] trig;
    logic [CH-1:0] cancel;
    logic [CW-1:0] len;
    logic [CW-1:0] hold;
    logic          retrig;
    logic [CH-1:0] ep;
    logic [CH-1:0] ed;
    logic          eb;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void add(input logic [CH-1:0] t, input logic [CH-1:0] c,
                              input logic [CW-1:0] l, input logic [CW-1:0] h,
                              input logic r, input logic [CH-1:0] ep,
                              input logic [CH-1:0] ed, input logic eb);
    vec_t v;
    v.trig = t; v.cancel = c; v.len = l; v.hold = h; v.retrig = r;
    v.ep = ep; v.ed = ed; v.eb = eb;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_e(input logic [CH-1:0] t, input logic [CH-1:0] c,
                         input logic [CW-1:0] l, input logic [CW-1:0] h, input logic r);
    bus_e.trig = t; bus_e.cancel = c; bus_e.len = l; bus_e.holdoff = h; bus_e.retrig = r;
  endtask

  initial begin
    drive_e('0, '0, '0, '0, 1'b0);
    bus_l.trig = '0; bus_l.cancel = '0; bus_l.len = '0; bus_l.holdoff = '0; bus_l.retrig = 1'b0;

    // single pulse, len=5, trig held 10 cycles
    for (int i = 0; i < 5; i++) add(4'h1, 4'h0, 5, 0, 0, 4'h1, 4'h0, 1);
    add(4'h1, 4'h0, 5, 0, 0, 4'h0, 4'h1, 0);
    for (int i = 0; i < 4; i++) add(4'h1, 4'h0, 5, 0, 0, 4'h0, 4'h0, 0);
    add(4'h0, 4'h0, 5, 0, 0, 4'h0, 4'h0, 0);
    // retrigger extends, len=4, edges at 0 and 3
    add(4'h1, 4'h0, 4, 0, 1, 4'h1, 4'h0, 1);
    add(4'h0, 4'h0, 4, 0, 1, 4'h1, 4'h0, 1);
    add(4'h0, 4'h0, 4, 0, 1, 4'h1, 4'h0, 1);
    add(4'h1, 4'h0, 4, 0, 1, 4'h1, 4'h0, 1);
    for (int i = 0; i < 3; i++) add(4'h0, 4'h0, 4, 0, 1, 4'h1, 4'h0, 1);
    add(4'h0, 4'h0, 4, 0, 1, 4'h0, 4'h1, 0);
    add(4'h0, 4'h0, 4, 0, 1, 4'h0, 4'h0, 0);
    // retrig off: second edge ignored
    add(4'h1, 4'h0, 4, 0, 0, 4'h1, 4'h0, 1);
    add(4'h0, 4'h0, 4, 0, 0, 4'h1, 4'h0, 1);
    add(4'h0, 4'h0, 4, 0, 0, 4'h1, 4'h0, 1);
    add(4'h1, 4'h0, 4, 0, 0, 4'h1, 4'h0, 1);
    add(4'h0, 4'h0, 4, 0, 0, 4'h0, 4'h1, 0);
    add(4'h0, 4'h0, 4, 0, 0, 4'h0, 4'h0, 0);
    // retrigger on the cnt==1 cycle wins
    add(4'h1, 4'h0, 2, 0, 1, 4'h1, 4'h0, 1);
    add(4'h0, 4'h0, 2, 0, 1, 4'h1, 4'h0, 1);
    add(4'h1, 4'h0, 2, 0, 1, 4'h1, 4'h0, 1);
    add(4'h0, 4'h0, 2, 0, 1, 4'h1, 4'h0, 1);
    add(4'h0, 4'h0, 2, 0, 1, 4'h0, 4'h1, 0);
    add(4'h0, 4'h0, 2, 0, 1, 4'h0, 4'h0, 0);
    // len=0 ignored; len=1 one-cycle pulse
    add(4'h1, 4'h0, 0, 0, 0, 4'h0, 4'h0, 0);
    add(4'h0, 4'h0, 0, 0, 0, 4'h0, 4'h0, 0);
    add(4'h1, 4'h0, 1, 0, 0, 4'h1, 4'h0, 1);
    add(4'h0, 4'h0, 1, 0, 0, 4'h0, 4'h1, 0);
    add(4'h0, 4'h0, 1, 0, 0, 4'h0, 4'h0, 0);
    // cancel with trigger in IDLE; cancel mid-pulse at count 2
    add(4'h1, 4'h1, 3, 0, 0, 4'h0, 4'h0, 0);
    add(4'h0, 4'h0, 3, 0, 0, 4'h0, 4'h0, 0);
    add(4'h1, 4'h0, 4, 0, 0, 4'h1, 4'h0, 1);
    add(4'h0, 4'h0, 4, 0, 0, 4'h1, 4'h0, 1);
    add(4'h0, 4'h0, 4, 0, 0, 4'h1, 4'h0, 1);
    add(4'h0, 4'h1, 4, 0, 0, 4'h0, 4'h0, 0);
    add(4'h0, 4'h0, 4, 0, 0, 4'h0, 4'h0, 0);
    // holdoff=3 with edges: ignored in holdoff, accepted at k+len+holdoff+1, cancel in holdoff
    add(4'h1, 4'h0, 2, 3, 0, 4'h1, 4'h0, 1);
    add(4'h0, 4'h0, 2, 3, 0, 4'h1, 4'h0, 1);
    add(4'h1, 4'h0, 2, 3, 0, 4'h0, 4'h1, 1);
    add(4'h0, 4'h0, 2, 3, 0, 4'h0, 4'h0, 1);
    add(4'h1, 4'h0, 2, 3, 0, 4'h0, 4'h0, 1);
    add(4'h0, 4'h0, 2, 3, 0, 4'h0, 4'h0, 0);
    add(4'h1, 4'h0, 2, 3, 0, 4'h1, 4'h0, 1);
    add(4'h0, 4'h0, 2, 3, 0, 4'h1, 4'h0, 1);
    add(4'h0, 4'h0, 2, 3, 0, 4'h0, 4'h1, 1);
    add(4'h0, 4'h1, 2, 3, 0, 4'h0, 4'h0, 0);
    add(4'h0, 4'h0, 0, 0, 0, 4'h0, 4'h0, 0);
    // cancel beats retrigger
    add(4'h1, 4'h0, 3, 0, 1, 4'h1, 4'h0, 1);
    add(4'h0, 4'h0, 3, 0, 1, 4'h1, 4'h0, 1);
    add(4'h1, 4'h1, 3, 0, 1, 4'h0, 4'h0, 0);
    add(4'h0, 4'h0, 3, 0, 1, 4'h0, 4'h0, 0);
    // len changed after load has no effect
    add(4'h1, 4'h0, 3, 0, 0, 4'h1, 4'h0, 1);
    add(4'h0, 4'h0, 9, 0, 0, 4'h1, 4'h0, 1);
    add(4'h0, 4'h0, 9, 0, 0, 4'h1, 4'h0, 1);
    add(4'h0, 4'h0, 9, 0, 0, 4'h0, 4'h1, 0);
    add(4'h0, 4'h0, 9, 0, 0, 4'h0, 4'h0, 0);
    // staggered lanes, each with its own len
    add(4'h1, 4'h0, 2, 0, 0, 4'h1, 4'h0, 1);
    add(4'h2, 4'h0, 3, 0, 0, 4'h3, 4'h0, 1);
    add(4'h4, 4'h0, 1, 0, 0, 4'h6, 4'h1, 1);
    add(4'h8, 4'h0, 4, 0, 0, 4'hA, 4'h4, 1);
    add(4'h0, 4'h0, 4, 0, 0, 4'h8, 4'h2, 1);
    add(4'h0, 4'h0, 4, 0, 0, 4'h8, 4'h0, 1);
    add(4'h0, 4'h0, 4, 0, 0, 4'h8, 4'h0, 1);
    add(4'h0, 4'h0, 4, 0, 0, 4'h0, 4'h8, 0);
    add(4'h0, 4'h0, 4, 0, 0, 4'h0, 4'h0, 0);
    // all lanes at once
    add(4'hF, 4'h0, 2, 0, 0, 4'hF, 4'h0, 1);
    add(4'h0, 4'h0, 2, 0, 0, 4'hF, 4'h0, 1);
    add(4'h0, 4'h0, 2, 0, 0, 4'h0, 4'hF, 0);
    add(4'h0, 4'h0, 2, 0, 0, 4'h0, 4'h0, 0);

    #1;
    chk("reset_pulse", CW'(bus_e.pulse), 0);
    chk("reset_done", CW'(bus_e.done), 0);
    chk("reset_busy", CW'(bus_e.any_busy), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    foreach (vq[i]) begin
      @(negedge clk);
      drive_e(vq[i].trig, vq[i].cancel, vq[i].len, vq[i].hold, vq[i].retrig);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_pulse", i), CW'(bus_e.pulse), CW'(vq[i].ep));
      chk($sformatf("vec%0d_done", i), CW'(bus_e.done), CW'(vq[i].ed));
      chk($sformatf("vec%0d_busy", i), CW'(bus_e.any_busy), CW'(vq[i].eb));
    end

    // async reset mid-STRETCH
    @(negedge clk); drive_e(4'h1, 4'h0, 5, 0, 0);
    @(posedge clk); @(negedge clk); drive_e(4'h0, 4'h0, 5, 0, 0);
    @(posedge clk); #1;
    chk("pre_rst_stretch_pulse", CW'(bus_e.pulse), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_stretch_pulse", CW'(bus_e.pulse), 0);
    chk("rst_stretch_busy", CW'(bus_e.any_busy), 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); drive_e(4'h1, 4'h0, 3, 0, 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst_pulse%0d", i), CW'(bus_e.pulse[0]), CW'(i < 3));
      chk($sformatf("post_rst_done%0d", i), CW'(bus_e.done[0]), CW'(i == 3));
      @(negedge clk); drive_e(4'h0, 4'h0, 3, 0, 0);
    end

    // async reset mid-HOLDOFF
    @(negedge clk); drive_e(4'h1, 4'h0, 1, 5, 0);
    @(posedge clk); @(negedge clk); drive_e(4'h0, 4'h0, 1, 5, 0);
    @(posedge clk); @(posedge clk); #1;
    chk("pre_rst_hold_busy", CW'(bus_e.any_busy), 1);
    chk("pre_rst_hold_pulse", CW'(bus_e.pulse), 0);
    #2 rst = 1'b1;
    #1;
    chk("rst_hold_busy", CW'(bus_e.any_busy), 0);
    chk("rst_hold_done", CW'(bus_e.done), 0);
    @(negedge clk); rst = 1'b0;

    // level trigger held: 3 high, holdoff 4, one accept cycle, repeating
    @(negedge clk);
    bus_l.trig = 4'h1; bus_l.len = 3; bus_l.holdoff = 4;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      chk($sformatf("lvl_pulse%0d", i), CW'(bus_l.pulse), CW'((i % 8) < 3));
      chk($sformatf("lvl_done%0d", i), CW'(bus_l.done), CW'((i % 8) == 3));
      chk($sformatf("lvl_busy%0d", i), CW'(bus_l.any_busy), CW'((i % 8) != 7));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher_bank.md
# pulse_stretcher_bank

Multi-channel, run-time programmable pulse stretcher. Successor to the fixed-length single-channel stretcher. Each of CHANNELS independent lanes turns a trigger into an output pulse of exactly `len` clock cycles. Each lane also supports retrigger-extend, a post-pulse holdoff window, optional rising-edge triggering, per-lane cancel, and a one-cycle done strobe. Used between button/debounce and note/LED logic wherever several stretched strobes are needed.

## Interface
- CHANNELS, 4: number of independent lanes (≥1)
- CNT_W, 16: width of length/holdoff counters
- EDGE_TRIG, 1: 1 = trigger on rising edge of trig[i]; 0 = trigger on level
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- trig  in  CHANNELS  per-lane trigger
- cancel  in  CHANNELS  per-lane synchronous abort
- len  in  CNT_W  pulse length in cycles, shared by all lanes
- holdoff  in  CNT_W  post-pulse dead time in cycles, shared by all lanes
- retrig  in  1  1 = a trigger during a pulse reloads the counter
- pulse  out  CHANNELS  stretched output; registered (pulse[i] = lane i in STRETCH)
- done  out  CHANNELS  one-cycle strobe when a pulse ends naturally
- any_busy  out  1  OR of all lanes not in IDLE

## Operation
- Per-lane states:
  - IDLE, STRETCH, HOLDOFF; each lane has its own cnt[CNT_W].
- Trigger event tev[i]:
  - EDGE_TRIG=1: trig[i] & ~trig_q[i].
  - EDGE_TRIG=0: trig[i].
  - trig_q updates every cycle in every state, including across cancel.
- IDLE:
  - tev & len≠0 → STRETCH, cnt←len.
  - tev with len==0 is ignored: no pulse, no done.
- STRETCH:
  - retrig & tev & len≠0 → cnt←len.
  - Otherwise, if cnt==1: → HOLDOFF with cnt←holdoff when holdoff≠0, else → IDLE; done←1 for one cycle.
  - Otherwise cnt←cnt−1.
  - Retrigger on the cnt==1 cycle wins: the lane stays in STRETCH and no done is issued.
- HOLDOFF:
  - Triggers are ignored.
  - cnt==1 → IDLE; else cnt←cnt−1.
  - A trigger in the final HOLDOFF cycle is also ignored.
- cancel[i]:
  - In any state, the lane → IDLE, cnt←0, with no done.
  - cancel beats a simultaneous trigger or retrigger.
- len and holdoff are sampled only at load; later changes do not affect a running count.
- Lanes are fully independent; simultaneous triggers on all lanes are legal.

## Timing
- Reset:
  - All lanes go to IDLE with cnt=0 and trig_q=0.
  - pulse=0, done=0, any_busy=0.
  - Reset mid-pulse drops pulse on assertion, asynchronously.
- Latency:
  - tev sampled at edge k → pulse high from edge k to edge k+len, i.e. exactly len cycles.
  - done is high during cycle k+len to k+len+1 (the first cycle pulse is low).
- Retrigger at edge j during STRETCH: pulse stays high until edge j+len.
- Holdoff:
  - After done, triggers are ignored for holdoff cycles.
  - The earliest accepted re-trigger is at edge k+len+holdoff+1 after the original trigger at k (with holdoff≠0). With holdoff==0 the earliest is k+len+1.
- cancel sampled at edge c: pulse low from edge c.
- Maximum pulse length: 2^CNT_W−1 cycles.
- Counters never wrap. cnt==0 is reached only via reset or cancel.

## Structure
- Shared package pulse_stretch_pkg holds:
  - lane state enum IDLE/STRETCH/HOLDOFF (2-bit);
  - default CNT_W.
- Sub-module pulse_stretch_lane, one per channel via generate:
  - ports clk, rst, tev, cancel, len, holdoff, retrig, pulse, done, busy.
- Top level handles edge detection (trig_q register), the generate loop, and any_busy.

## Test plan
- Single pulse: EDGE_TRIG=1, len=5, holdoff=0, trig lane0 high for 10 cycles → pulse[0] high exactly 5 cycles, done[0] one cycle after, no second pulse.
- Retrigger: len=4, retrig=1, edges at cycles 0 and 3 → pulse high cycles 1–7 (7 cycles), single done. With retrig=0 → 4-cycle pulse, edge at 3 ignored.
- Holdoff: len=3, holdoff=4, triggers every cycle (EDGE_TRIG=0) → pattern of 3 high, 4 low + 1 accept cycle, repeating. done once per pulse.
- Boundary: len=0 trigger → no pulse, no done. len=1 → 1-cycle pulse. Cancel coincident with trigger in IDLE → nothing. Cancel mid-pulse at count 2 → pulse drops next edge, no done.
- Multi-lane: distinct triggers on lanes 0–3 at staggered cycles, len changed between them → each lane uses len at its own trigger. any_busy equals the OR of lane states.
- Async reset asserted mid-STRETCH and mid-HOLDOFF → all outputs 0 immediately. First trigger after release gives a full len pulse.
